// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: state encodings and
// the counter sizing helper.
package serial_adder_ctrl_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // The counter must be able to hold WIDTH-1 for every legal WIDTH (1..32).
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Start/done request interface between a requester and the serial adder.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;

  modport master (output start, op_a, op_b, input busy, done, result, carry_out);
  modport slave  (input start, op_a, op_b, output busy, done, result, carry_out);
endinterface

// File: rtl/halfadder.sv
// Existing half-adder cell reused by the serial full-adder stage.
module halfadder (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;
endmodule

// File: rtl/serial_fa_stage.sv
// Combinational full-adder bit stage built from two half-adders and an OR.
module serial_fa_stage (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);
  logic s1;
  logic c1;
  logic c2;

  halfadder u_ha0 (.a_i(a_i), .b_i(b_i),   .s_o(s1),  .c_o(c1));
  halfadder u_ha1 (.a_i(s1),  .b_i(cin_i), .s_o(s_o), .c_o(c2));

  assign cout_o = c1 | c2;
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one shared full-adder stage processes one bit per clock,
// LSB first, with the sum shifted into the result from the MSB end.
//
// state   | meaning
// IDLE    | waiting for start; result/carry_out held
// RUN     | one bit per edge, WIDTH edges total
// DONE    | one-cycle completion pulse, then back to IDLE
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  serial_adder_ctrl_if.slave bus
);
  localparam int CNT_W = cnt_width(WIDTH);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;
  logic [WIDTH-1:0] res_q,   res_d;
  logic             carry_q, carry_d;
  logic             cout_q,  cout_d;

  logic fa_sum;
  logic fa_cout;

  serial_fa_stage u_fa (
    .a_i   (a_q[0]),
    .b_i   (b_q[0]),
    .cin_i (carry_q),
    .s_o   (fa_sum),
    .cout_o(fa_cout)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_d     = bus.op_a;
          b_d     = bus.op_b;
          res_d   = '0;
          carry_d = 1'b0;
          cout_d  = 1'b0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_d              = a_q >> 1;
        b_d              = b_q >> 1;
        res_d            = res_q >> 1;
        res_d[WIDTH-1]   = fa_sum;
        carry_d          = fa_cout;
        cnt_d            = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          cout_d  = fa_cout;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  assign bus.busy      = (state_q == ST_RUN);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.result    = res_q;
  assign bus.carry_out = cout_q;
endmodule
